// File: rtl/tile_burst_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tile_burst_addr_gen_pkg
// Purpose : Shared types and helpers for the tile burst address generator:
//           matrix / datatype / shape-code types, the FSM state encoding,
//           the burst request record and the tile sizing functions.
// Revision: 1.0 - initial release
// ============================================================================
package tile_burst_addr_gen_pkg;

    typedef enum logic [1:0] {
        MAT_A = 2'd0,
        MAT_B = 2'd1,
        MAT_C = 2'd2
    } mat_t;

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP16 = 2'd1,
        INT8 = 2'd2,
        INT4 = 2'd3
    } type_t;

    typedef logic [1:0] rc_t;
    localparam rc_t RC_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } agen_state_t;

    // Internal address datapath is held at the widest supported address;
    // the top slices it down to its ADDR_W.
    localparam int TILE_ADDR_MAX_W = 64;
    // Beat counts: worst case is 512 elems * 32 bits / 64-bit bus = 256.
    localparam int BEATS_W = 16;

    typedef struct packed {
        logic [TILE_ADDR_MAX_W-1:0] addr;
        logic [7:0]                 len;
    } tile_req_t;

    // Bits per element; the C accumulator is always 32-bit.
    function automatic logic [5:0] elem_bits(input type_t dtype, input mat_t mat);
        logic [5:0] bits;
        if (mat == MAT_C) begin
            bits = 6'd32;
        end else begin
            case (dtype)
                FP32:    bits = 6'd32;
                FP16:    bits = 6'd16;
                INT8:    bits = 6'd8;
                default: bits = 6'd4;
            endcase
        end
        return bits;
    endfunction

    // Elements per tile for the given matrix and shape code.
    function automatic logic [9:0] tile_elems(input mat_t mat, input rc_t rc);
        logic [9:0] elems;
        case (mat)
            MAT_A: begin
                case (rc)
                    2'b00:   elems = 10'd512;
                    2'b01:   elems = 10'd256;
                    default: elems = 10'd128;
                endcase
            end
            MAT_B: begin
                case (rc)
                    2'b00:   elems = 10'd128;
                    2'b01:   elems = 10'd256;
                    default: elems = 10'd512;
                endcase
            end
            default: elems = 10'd256;
        endcase
        return elems;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_burst_addr_gen_size_calc.sv
`default_nettype none
// ============================================================================
// Module  : tile_size_calc
// Purpose : Combinational tile sizing: descriptor -> total beats on the bus,
//           plus an illegal-descriptor flag.
// Ports   : mat, dtype, rc   - tile descriptor fields
//           total_beats      - elems*ebits/DATA_W, never less than 1
//           illegal          - shape code 11 or unknown matrix
// Revision: 1.0 - initial release
// ============================================================================
module tile_size_calc
    import tile_burst_addr_gen_pkg::*;
#(
    parameter int DATA_W = 256
) (
    input  mat_t               mat,
    input  type_t              dtype,
    input  rc_t                rc,
    output logic [BEATS_W-1:0] total_beats,
    output logic               illegal
);

    localparam int BEAT_SHIFT = $clog2(DATA_W);

    logic [BEATS_W-1:0] w_bits;
    logic [BEATS_W-1:0] w_beats;

    always_comb begin
        w_bits      = BEATS_W'(tile_elems(mat, rc)) * BEATS_W'(elem_bits(dtype, mat));
        w_beats     = w_bits >> BEAT_SHIFT;
        // A tile narrower than one bus word still costs one beat.
        total_beats = (w_beats == '0) ? BEATS_W'(1) : w_beats;
        illegal     = (rc == RC_ILLEGAL) || !(mat inside {MAT_A, MAT_B, MAT_C});
    end

endmodule
`default_nettype wire

// File: rtl/tile_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : tile_burst_addr_gen
// Purpose : Turns one tile descriptor into a stream of read-burst requests
//           and tracks returned bursts until the tile is complete.
// Ports   : clk, rst_n                 - clock, async active-low reset
//           cfg_valid/cfg_ready        - descriptor handshake (ready in IDLE)
//           cfg_mat/dtype/rc/base      - descriptor fields
//           abort                      - synchronous flush to IDLE
//           req_valid/ready/addr/len   - burst request (len = beats-1)
//           beat_valid/beat_last       - returned read beats
//           busy, done, err            - status; done/err are 1-cycle pulses
// Config  : TILE_BURST_ADDR_GEN_PERF_EN adds perf_cycles / perf_stall.
// Revision: 1.0 - initial release
// ============================================================================
module tile_burst_addr_gen
    import tile_burst_addr_gen_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int MAX_BURST = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  mat_t              cfg_mat,
    input  type_t             cfg_dtype,
    input  rc_t               cfg_rc,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              abort,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [7:0]        req_len,
    input  logic              beat_valid,
    input  logic              beat_last,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef TILE_BURST_ADDR_GEN_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall
`endif
);

    localparam int                         OUTST_W        = 5;
    localparam logic [OUTST_W-1:0]         OUTST_MAX      = OUTST_W'(MAX_OUTST);
    localparam logic [BEATS_W-1:0]         BURST_BEATS    = BEATS_W'(MAX_BURST);
    localparam logic [TILE_ADDR_MAX_W-1:0] BYTES_PER_BEAT = TILE_ADDR_MAX_W'(DATA_W / 8);

    agen_state_t        r_state;
    agen_state_t        w_state_next;
    tile_req_t          r_req;
    logic [BEATS_W-1:0] r_remain;
    logic [OUTST_W-1:0] r_outst;
    logic [7:0]         r_late;
    logic               r_err;

    logic [BEATS_W-1:0] w_total_beats;
    logic               w_illegal;
    logic               w_accept;
    logic               w_cfg_ok;
    logic               w_hs;
    logic               w_beat_ret;
    logic               w_late_ret;
    logic               w_retire;
    logic               w_stray;
    logic [OUTST_W-1:0] w_outst_next;
    logic [BEATS_W-1:0] w_burst_beats;
    logic [BEATS_W-1:0] w_remain_after;
    logic               w_last_burst;

    tile_size_calc #(
        .DATA_W      (DATA_W)
    ) u_size_calc (
        .mat         (cfg_mat),
        .dtype       (cfg_dtype),
        .rc          (cfg_rc),
        .total_beats (w_total_beats),
        .illegal     (w_illegal)
    );

    // Length field (beats-1) of a burst starting with `beats` still to fetch.
    function automatic logic [7:0] burst_len(input logic [BEATS_W-1:0] beats);
        if (beats >= BURST_BEATS) begin
            return 8'(MAX_BURST - 1);
        end
        return 8'(beats - BEATS_W'(1));
    endfunction

    always_comb begin
        w_accept       = (r_state == IDLE) && cfg_valid;
        w_cfg_ok       = w_accept && !w_illegal;
        w_hs           = req_valid && req_ready;
        w_beat_ret     = beat_valid && beat_last;
        // Bursts orphaned by an abort still return; they are swallowed
        // before anything is credited to the current tile.
        w_late_ret     = w_beat_ret && (r_late != 8'd0);
        w_retire       = w_beat_ret && (r_late == 8'd0) && (r_outst != '0);
        w_stray        = w_beat_ret && (r_late == 8'd0) && (r_outst == '0);
        w_outst_next   = r_outst + OUTST_W'(w_hs) - OUTST_W'(w_retire);
        w_burst_beats  = BEATS_W'(r_req.len) + BEATS_W'(1);
        w_remain_after = r_remain - w_burst_beats;
        w_last_burst   = (r_remain == w_burst_beats);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_cfg_ok) w_state_next = ISSUE;
            ISSUE:   if (w_hs && w_last_burst) w_state_next = DRAIN;
            DRAIN:   if (w_outst_next == '0) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (abort) begin
            w_state_next = IDLE;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cfg_ready = (r_state == IDLE);
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
        req_valid = (r_state == ISSUE) && (r_outst < OUTST_MAX);
        req_addr  = r_req.addr[ADDR_W-1:0];
        req_len   = r_req.len;
        err       = r_err;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req    <= '0;
            r_remain <= '0;
            r_outst  <= '0;
            r_late   <= '0;
            r_err    <= 1'b0;
        end else if (abort) begin
            // Everything in flight becomes "late"; any handshake or beat
            // presented alongside the abort is ignored.
            r_req    <= '0;
            r_remain <= '0;
            r_outst  <= '0;
            r_late   <= r_late + 8'(r_outst);
            r_err    <= 1'b0;
        end else begin
            r_err   <= (w_accept && w_illegal) || w_stray;
            r_outst <= w_outst_next;
            if (w_late_ret) begin
                r_late <= r_late - 8'd1;
            end
            if (w_cfg_ok) begin
                r_req.addr <= TILE_ADDR_MAX_W'(cfg_base);
                r_req.len  <= burst_len(w_total_beats);
                r_remain   <= w_total_beats;
            end else if (w_hs) begin
                r_req.addr <= r_req.addr + TILE_ADDR_MAX_W'(w_burst_beats) * BYTES_PER_BEAT;
                r_remain   <= w_remain_after;
                if (!w_last_burst) begin
                    r_req.len <= burst_len(w_remain_after);
                end
            end
        end
    end

    // Address bits above ADDR_W are carried but never leave the block.
    generate
        if (ADDR_W < TILE_ADDR_MAX_W) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^r_req.addr[TILE_ADDR_MAX_W-1:ADDR_W];
        end
    endgenerate

`ifdef TILE_BURST_ADDR_GEN_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (w_cfg_ok && !abort) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if ((r_state == ISSUE) || (r_state == DRAIN)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (req_valid && !req_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_tile_burst_addr_gen
// Purpose : Self-checking bench for tile_burst_addr_gen. A stimulus process
//           issues descriptors, ready and returned beats; a monitor at the
//           falling edge predicts requests / done / err from the tile rules
//           and compares against the DUT.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tile_burst_addr_gen;
    import tile_burst_addr_gen_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 256;
    localparam int MAX_BURST = 16;
    localparam int MAX_OUTST = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    mat_t              cfg_mat;
    type_t             cfg_dtype;
    rc_t               cfg_rc;
    logic [ADDR_W-1:0] cfg_base;
    logic              abort;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_len;
    logic              beat_valid;
    logic              beat_last;
    logic              busy;
    logic              done;
    logic              err;
`ifdef TILE_BURST_ADDR_GEN_PERF_EN
    logic [31:0]       perf_cycles;
    logic [31:0]       perf_stall;
`endif

    tile_burst_addr_gen #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mat    (cfg_mat),
        .cfg_dtype  (cfg_dtype),
        .cfg_rc     (cfg_rc),
        .cfg_base   (cfg_base),
        .abort      (abort),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .beat_valid (beat_valid),
        .beat_last  (beat_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef TILE_BURST_ADDR_GEN_PERF_EN
        ,
        .perf_cycles(perf_cycles),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint addr;
        int     len;
    } exp_req_t;

    exp_req_t req_q[$];

    // Expands a descriptor into its expected bursts; returns the burst count.
    function automatic int push_tile(input int mat, input int dtype, input int rc, input longint base);
        int     elems, ebits, beats, n, cnt;
        longint addr;
        if (mat == 0)      elems = (rc == 0) ? 512 : (rc == 1) ? 256 : 128;
        else if (mat == 1) elems = (rc == 0) ? 128 : (rc == 1) ? 256 : 512;
        else               elems = 256;
        if (mat == 2) ebits = 32;
        else          ebits = (dtype == 0) ? 32 : (dtype == 1) ? 16 : (dtype == 2) ? 8 : 4;
        beats = elems * ebits / DATA_W;
        if (beats < 1) beats = 1;
        addr = base;
        cnt  = 0;
        while (beats > 0) begin
            n = (beats > MAX_BURST) ? MAX_BURST : beats;
            req_q.push_back('{addr: addr & 64'hFFFF_FFFF, len: n - 1});
            addr  += n * (DATA_W / 8);
            beats -= n;
            cnt++;
        end
        return cnt;
    endfunction

    // Monitor-owned model state.
    int mon_outst   = 0;
    int mon_late    = 0;
    int tile_bursts = 0;
    int tile_ret    = 0;
    bit tile_active = 0;
    int done_due    = -1;
    int err_due     = -1;
    int hs_total    = 0;
    int dones_seen  = 0;
    bit m_idle, m_hs, m_exp_done, m_exp_err;
    exp_req_t m_e;

    always @(negedge clk) begin
        if (rst_n) begin
            m_idle     = !tile_active && (done_due != cyc);
            m_exp_done = (done_due == cyc);
            m_exp_err  = (err_due == cyc);
            if (done || m_exp_done) begin
                check("done_pulse", done, m_exp_done);
                if (done) dones_seen++;
            end
            if (err || m_exp_err) check("err_pulse", err, m_exp_err);
            if (cfg_valid) check("cfg_ready", cfg_ready, m_idle);
            if (req_valid) check("outst_limit", (mon_outst < MAX_OUTST), 1);
            m_hs = req_valid && req_ready;
            if (m_hs) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 1, 0);
                end else begin
                    m_e = req_q.pop_front();
                    check("req_addr", req_addr, m_e.addr);
                    check("req_len", req_len, m_e.len);
                end
                hs_total++;
            end
            // Advance the model by what the coming edge samples.
            if (abort) begin
                mon_late   += mon_outst;
                mon_outst   = 0;
                tile_active = 0;
                req_q.delete();
            end else begin
                if (beat_valid && beat_last) begin
                    if (mon_late > 0) begin
                        mon_late--;
                    end else if (mon_outst > 0) begin
                        mon_outst--;
                        if (tile_active) begin
                            tile_ret++;
                            if (tile_ret == tile_bursts) begin
                                done_due    = cyc + 1;
                                tile_active = 0;
                            end
                        end
                    end else begin
                        err_due = cyc + 1;
                    end
                end
                if (m_hs) mon_outst++;
                if (cfg_valid && m_idle) begin
                    if (cfg_rc == 2'b11) begin
                        err_due = cyc + 1;
                    end else begin
                        tile_bursts = push_tile(int'(cfg_mat), int'(cfg_dtype), int'(cfg_rc), longint'(cfg_base));
                        tile_ret    = 0;
                        tile_active = 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int   ready_mode  = 0;   // 0 always, 1 random, 2 never, 3 until one handshake
    int   hs_mark     = 0;
    int   beat_budget = -1;  // -1 unlimited, else beats still allowed
    int   beats_sent  = 0;
    bit   do_cfg      = 0;
    bit   do_abort    = 0;
    bit   do_stray    = 0;
    int   nxt_mat, nxt_dtype, nxt_rc;
    logic [ADDR_W-1:0] nxt_base;

    task automatic tick();
        @(posedge clk);
        #1;
        cfg_valid  = 1'b0;
        abort      = 1'b0;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        case (ready_mode)
            0:       req_ready = 1'b1;
            1:       req_ready = ($urandom % 3) != 0;
            3:       req_ready = (hs_total == hs_mark);
            default: req_ready = 1'b0;
        endcase
        if (do_abort) begin
            abort     = 1'b1;
            req_ready = 1'b0;
            do_abort  = 0;
        end else if (do_stray) begin
            beat_valid = 1'b1;
            beat_last  = 1'b1;
            do_stray   = 0;
        end else if (beat_budget != 0 && (hs_total - beats_sent) > 0 &&
                     (beat_budget > 0 || ($urandom % 2) == 0)) begin
            beat_valid = 1'b1;
            beat_last  = 1'b1;
            beats_sent++;
            if (beat_budget > 0) beat_budget--;
        end else if (($urandom % 6) == 0) begin
            beat_valid = 1'b1;
        end
        if (do_cfg && cfg_ready) begin
            cfg_valid = 1'b1;
            cfg_mat   = mat_t'(nxt_mat[1:0]);
            cfg_dtype = type_t'(nxt_dtype[1:0]);
            cfg_rc    = rc_t'(nxt_rc[1:0]);
            cfg_base  = nxt_base;
            do_cfg    = 0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cfg(input int m, input int d, input int r, input logic [ADDR_W-1:0] b);
        int guard;
        nxt_mat = m; nxt_dtype = d; nxt_rc = r; nxt_base = b;
        do_cfg = 1;
        guard  = 0;
        while (do_cfg && guard < 500) begin
            tick();
            guard++;
        end
        if (do_cfg) begin
            check("cfg_timeout", 1, 0);
            do_cfg = 0;
        end
    endtask

    task automatic wait_done(input string name);
        int d0, guard;
        d0 = dones_seen;
        guard = 0;
        while (dones_seen == d0 && guard < 3000) begin
            tick();
            guard++;
        end
        if (dones_seen == d0) check(name, 0, 1);
    endtask

    task automatic wait_quiet();
        int guard;
        guard = 0;
        beat_budget = -1;
        while ((hs_total != beats_sent || busy) && guard < 3000) begin
            tick();
            guard++;
        end
        ticks(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, m, r;
        rst_n = 1'b0; cfg_valid = 1'b0; abort = 1'b0; req_ready = 1'b0;
        beat_valid = 1'b0; beat_last = 1'b0;
        cfg_mat = MAT_A; cfg_dtype = FP32; cfg_rc = 2'b00; cfg_base = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_req_valid", req_valid, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_req_len", req_len, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1. A FP32 rc00: four 16-beat bursts.
        ready_mode = 0;
        send_cfg(0, 0, 0, 32'h1000);
        wait_done("t1_done_timeout");
        wait_quiet();

        // 2. B INT4 rc00: one 2-beat burst.
        send_cfg(1, 3, 0, 32'h40);
        wait_done("t2_done_timeout");
        wait_quiet();

        // 3. C INT8 rc10: C is 32-bit regardless of dtype.
        ready_mode = 1;
        send_cfg(2, 2, 2, 32'h0);
        wait_done("t3_done_timeout");
        wait_quiet();

        // 4. Illegal shape code, then a stray beat_last while idle.
        send_cfg(0, 0, 3, 32'h100);
        ticks(4);
        @(negedge clk);
        check("illegal_req_valid", req_valid, 0);
        check("illegal_cfg_ready", cfg_ready, 1);
        do_stray = 1;
        ticks(4);

        // 5. Outstanding limit: no beats returned -> exactly MAX_OUTST requests.
        ready_mode  = 0;
        beat_budget = 0;
        hs0 = hs_total;
        send_cfg(0, 0, 0, 32'h8000);
        ticks(12);
        @(negedge clk);
        check("throttle_hs", hs_total - hs0, MAX_OUTST);
        check("throttle_req_valid", req_valid, 0);
        beat_budget = 1;
        ticks(12);
        check("throttle_one_more", hs_total - hs0, MAX_OUTST + 1);
        beat_budget = -1;
        wait_done("t5_done_timeout");
        wait_quiet();

        // 6. Abort after one handshake; new tile accepted immediately.
        beat_budget = 0;
        hs_mark     = hs_total;
        ready_mode  = 3;
        send_cfg(0, 0, 0, 32'h4000);
        for (int g = 0; g < 20 && hs_total == hs_mark; g++) tick();
        check("abort_one_hs", hs_total - hs_mark, 1);
        do_abort = 1;
        tick();
        beat_budget = -1;
        ready_mode  = 1;
        nxt_mat = 1; nxt_dtype = 1; nxt_rc = 1; nxt_base = 32'h2000;
        do_cfg = 1;
        tick();
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_req_valid", req_valid, 0);
        check("abort_no_done", done, 0);
        check("abort_cfg_taken", do_cfg, 0);
        wait_done("t6_done_timeout");
        wait_quiet();

        // Randomised descriptors with occasional aborts.
        for (int t = 0; t < 30; t++) begin
            m = $urandom % 3;
            r = (($urandom % 8) == 0) ? 3 : ($urandom % 3);
            ready_mode = $urandom % 2;
            send_cfg(m, $urandom % 4, r, ($urandom & 32'h0FFF_FFE0));
            if (r == 3) begin
                ticks(3);
            end else if (($urandom % 4) == 0) begin
                ticks(1 + ($urandom % 20));
                do_abort = 1;
                tick();
            end else begin
                wait_done("rand_done_timeout");
            end
            if (($urandom % 3) == 0) wait_quiet();
        end
        wait_quiet();
        ticks(5);
        check("final_queue_empty", req_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
